// File: rtl/arm_pkg.sv
// Shared types and constants for the EX operand stage: the zero-register index,
// the ALU opcode encodings and the captured ID/EX record.
package arm_pkg;

  localparam int DATA_W = 64;
  localparam int REG_W  = 5;

  localparam logic [REG_W-1:0] XZR = 5'd31;

  localparam logic [3:0] ALU_AND    = 4'b0000;
  localparam logic [3:0] ALU_OR     = 4'b0001;
  localparam logic [3:0] ALU_ADD    = 4'b0010;
  localparam logic [3:0] ALU_SUB    = 4'b0110;
  localparam logic [3:0] ALU_PASS_B = 4'b0111;
  localparam logic [3:0] ALU_XOR    = 4'b1100;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              alu_src;
    logic [3:0]        alu_control;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rn;
    logic [REG_W-1:0]  rm;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
  } idex_t;

endpackage

// File: rtl/fwd_mux.sv
// Three-way priority operand select: EX/MEM result, then MEM/WB result, then the
// value captured from the register file. The zero register is never forwarded.
module fwd_mux
  import arm_pkg::*;
#(
  parameter int N    = DATA_W,
  parameter int REGW = REG_W
) (
  input  logic [REGW-1:0] r,
  input  logic [N-1:0]    d,
  input  logic            mem_reg_write,
  input  logic [REGW-1:0] mem_rd,
  input  logic [N-1:0]    mem_result,
  input  logic            wb_reg_write,
  input  logic [REGW-1:0] wb_rd,
  input  logic [N-1:0]    wb_result,
  output logic [N-1:0]    q
);

  localparam logic [REGW-1:0] ZERO_REG = REGW'(XZR);

  logic not_zero;
  assign not_zero = (r != ZERO_REG);

  always_comb begin
    q = d;
    if (mem_reg_write && (mem_rd == r) && not_zero) q = mem_result;
    else if (wb_reg_write && (wb_rd == r) && not_zero) q = wb_result;
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding feeding the ALU.
// Register update priority each edge: flush (bubble) > stall (hold) > load.
module ex_operand_stage
  import arm_pkg::*;
#(
  parameter int N    = DATA_W,
  parameter int REGW = REG_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [N-1:0]    id_rd1,
  input  logic [N-1:0]    id_rd2,
  input  logic [N-1:0]    id_imm,
  input  logic [REGW-1:0] id_rn,
  input  logic [REGW-1:0] id_rm,
  input  logic [REGW-1:0] id_rd,
  input  logic            id_alu_src,
  input  logic [3:0]      id_alu_control,
  input  logic            id_reg_write,
  input  logic            mem_reg_write,
  input  logic [REGW-1:0] mem_rd,
  input  logic [N-1:0]    mem_result,
  input  logic            wb_reg_write,
  input  logic [REGW-1:0] wb_rd,
  input  logic [N-1:0]    wb_result,
  output logic            ex_valid,
  output logic [N-1:0]    alu_a,
  output logic [N-1:0]    alu_b,
  output logic [3:0]      alu_control,
  output logic [REGW-1:0] ex_rd,
  output logic            ex_reg_write,
  output logic [N-1:0]    ex_store_data
);

  idex_t       idex;
  logic [N-1:0] fwd_rm;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex <= '0;
    end else if (flush) begin
      idex <= '0;
    end else if (!stall) begin
      idex.valid       <= id_valid;
      // An invalid slot must never write back, whatever ID decoded.
      idex.reg_write   <= id_valid & id_reg_write;
      idex.alu_src     <= id_alu_src;
      idex.alu_control <= id_alu_control;
      idex.rd          <= id_rd;
      idex.rn          <= id_rn;
      idex.rm          <= id_rm;
      idex.rd1         <= id_rd1;
      idex.rd2         <= id_rd2;
      idex.imm         <= id_imm;
    end
  end

  fwd_mux #(.N(N), .REGW(REGW)) u_fwd_rn (
    .r             (idex.rn),
    .d             (idex.rd1),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .mem_result    (mem_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_result     (wb_result),
    .q             (alu_a)
  );

  fwd_mux #(.N(N), .REGW(REGW)) u_fwd_rm (
    .r             (idex.rm),
    .d             (idex.rd2),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .mem_result    (mem_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_result     (wb_result),
    .q             (fwd_rm)
  );

  assign alu_b         = idex.alu_src ? idex.imm : fwd_rm;
  assign ex_store_data = fwd_rm;
  assign ex_valid      = idex.valid;
  assign ex_reg_write  = idex.reg_write & idex.valid;
  assign ex_rd         = idex.rd;
  assign alu_control   = idex.alu_control;

endmodule
